// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - capture monitor for a multiplexed 7-segment display
// Rebuilds the four scanned BCD digits {d,c,b,a} into one coherent frame.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2097152
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode_n,
    input  logic [6:0]  seg_n,
    output logic [15:0] bcd_out,
    output logic        frame_stb,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        timeout
);

    localparam int STAB_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SETTLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [10:0]       sync1_q;
    logic [10:0]       s_q;
    logic [10:0]       s_prev_q;
    logic [STAB_W-1:0] stab_q,     stab_d;
    logic              captured_q, captured_d;
    logic [15:0]       shadow_q,   shadow_d;
    logic [3:0]        seen_q,     seen_d;
    logic              err_acc_q,  err_acc_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;

    logic [3:0] s_anode;
    logic [6:0] s_seg;
    logic       changed;
    logic       slot_vld;
    logic [1:0] slot;
    logic [3:0] code;
    logic       code_bad;
    logic       capture;
    logic       complete;
    logic       expire;

    assign s_anode = s_q[10:7];
    assign s_seg   = s_q[6:0];
    assign changed = (s_q != s_prev_q);

    always_comb begin
        slot_vld = 1'b1;
        slot     = 2'd0;
        case (s_anode)
            4'b0111: slot = 2'd3;
            4'b1011: slot = 2'd2;
            4'b1101: slot = 2'd1;
            4'b1110: slot = 2'd0;
            default: slot_vld = 1'b0;
        endcase
    end

    // Segment order is {a,b,c,d,e,f,g}, active-low.
    always_comb begin
        code_bad = 1'b0;
        code     = 4'hF;
        case (s_seg)
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001111: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            default:    code_bad = 1'b1;
        endcase
    end

    // Capture fires on the sample where the count reaches SETTLE_CYCLES, once per dwell.
    assign capture  = !changed && (stab_q == STAB_LAST) && !captured_q && slot_vld;
    assign complete = (seen_q == 4'b1111);
    assign expire   = (to_cnt_q == TO_LAST);

    always_comb begin
        stab_d     = stab_q;
        captured_d = captured_q;
        shadow_d   = shadow_q;
        seen_d     = complete ? 4'b0000 : seen_q;
        err_acc_d  = complete ? 1'b0 : err_acc_q;
        to_cnt_d   = to_cnt_q;

        if (changed) begin
            stab_d     = '0;
            captured_d = 1'b0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 1'b1;
        end

        if (capture) begin
            captured_d                  = 1'b1;
            shadow_d[{slot, 2'b00} +: 4] = code;
            seen_d[slot]                = 1'b1;
            err_acc_d                   = err_acc_d | code_bad;
        end

        if (complete) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            s_q         <= '0;
            s_prev_q    <= '0;
            stab_q      <= '0;
            captured_q  <= 1'b0;
            shadow_q    <= '0;
            seen_q      <= '0;
            err_acc_q   <= 1'b0;
            to_cnt_q    <= '0;
            bcd_out     <= '0;
            frame_stb   <= 1'b0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            sync1_q    <= {anode_n, seg_n};
            s_q        <= sync1_q;
            s_prev_q   <= s_q;
            stab_q     <= stab_d;
            captured_q <= captured_d;
            shadow_q   <= shadow_d;
            seen_q     <= seen_d;
            err_acc_q  <= err_acc_d;
            to_cnt_q   <= to_cnt_d;
            frame_stb  <= complete;
            // A completing frame takes priority over a coincident timeout expiry.
            if (complete) begin
                bcd_out     <= shadow_q;
                seg_err     <= err_acc_q;
                frame_valid <= 1'b1;
                timeout     <= 1'b0;
            end else if (expire) begin
                frame_valid <= 1'b0;
                timeout     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  anode_n = 4'hF;
    logic [6:0]  seg_n = 7'h7F;
    logic [15:0] bcd_out;
    logic        frame_stb;
    logic        frame_valid;
    logic        seg_err;
    logic        timeout;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .anode_n    (anode_n),
        .seg_n      (seg_n),
        .bcd_out    (bcd_out),
        .frame_stb  (frame_stb),
        .frame_valid(frame_valid),
        .seg_err    (seg_err),
        .timeout    (timeout)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        err;
    } frame_t;

    frame_t      exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          stb_count = 0;
    int          last_stb_cycle = 0;
    int          pushed = 0;

    logic [6:0]  pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    logic [10:0] m_cur;
    int          m_run;
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_seen;
    logic        m_err;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = 4'b0;
        m_err  = 1'b0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
        m_cur  = {4'hF, 7'h7F};
        m_run  = 1000;
    endtask

    // A one-hot-low anode names the slot; the pattern is looked up in the digit table.
    task automatic model_capture(input logic [3:0] an, input logic [6:0] sg);
        int   slot;
        logic [3:0] code;
        logic bad;
        slot = -1;
        for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) slot = i;
        if (slot < 0) return;
        code = 4'hF;
        bad  = 1'b1;
        for (int d = 0; d < 10; d++) begin
            if (pat[d] == sg) begin
                code = 4'(d);
                bad  = 1'b0;
            end
        end
        m_shadow[slot] = code;
        m_seen[slot]   = 1'b1;
        m_err          = m_err | bad;
        if (m_seen == 4'hF) begin
            exp_q.push_back({m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0], m_err});
            pushed++;
            m_seen = 4'b0;
            m_err  = 1'b0;
        end
    endtask

    // Holding a value for n cycles; a digit is taken once the run spans SETTLE+1 samples.
    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
        int prev;
        if ({an, sg} == m_cur) begin
            prev  = m_run;
            m_run = m_run + n;
        end else begin
            m_cur = {an, sg};
            prev  = 0;
            m_run = n;
        end
        if (prev < SETTLE + 1 && m_run >= SETTLE + 1) model_capture(an, sg);
        anode_n = an;
        seg_n   = sg;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int slot, input int d, input int n);
        drive(~(4'b0001 << slot), pat[d], n);
    endtask

    task automatic blank(input int n);
        drive(4'hF, 7'h7F, n);
    endtask

    task automatic scan4(input int d3, input int d2, input int d1, input int d0);
        digit(3, d3, 20);
        digit(2, d2, 20);
        digit(1, d1, 20);
        digit(0, d0, 20);
        blank(20);
    endtask

    initial begin : monitor
        frame_t e;
        forever begin
            @(negedge clk);
            if (!reset && frame_stb) begin
                stb_count++;
                last_stb_cycle = cycle;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got bcd_out=%h with no frame expected", bcd_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_bcd", 32'(bcd_out), 32'(e.bcd));
                    chk("frame_seg_err", 32'(seg_err), 32'(e.err));
                    chk("frame_valid_at_stb", 32'(frame_valid), 32'd1);
                    chk("timeout_at_stb", 32'(timeout), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        int r;
        int len;
        logic [3:0] an;
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_bcd", 32'(bcd_out), 32'h0);
        chk("reset_stb", 32'(frame_stb), 32'h0);
        chk("reset_valid", 32'(frame_valid), 32'h0);
        chk("reset_seg_err", 32'(seg_err), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        blank(10);

        n0 = stb_count;
        digit(3, 1, 1000);
        digit(2, 2, 1000);
        digit(1, 3, 1000);
        digit(0, 4, 1000);
        blank(20);
        chk("t1_bcd", 32'(bcd_out), 32'h1234);
        chk("t1_one_stb", 32'(stb_count - n0), 32'd1);
        chk("t1_valid", 32'(frame_valid), 32'd1);

        digit(0, 7, SETTLE - 1);
        blank(10);
        scan4(0, 0, 0, 9);
        chk("t2_bcd", 32'(bcd_out), 32'h0009);

        digit(3, 5, 20);
        digit(2, 5, 20);
        drive(4'b1101, 7'h7F, 20);
        digit(0, 5, 20);
        blank(20);
        chk("t3_bcd", 32'(bcd_out), 32'h55F5);
        chk("t3_err", 32'(seg_err), 32'd1);
        scan4(1, 2, 3, 4);
        chk("t3_err_cleared", 32'(seg_err), 32'd0);

        digit(3, 9, 15); blank(15);
        digit(2, 8, 15); blank(15);
        digit(1, 7, 15); blank(15);
        digit(0, 6, 15); blank(15);
        chk("t4_bcd", 32'(bcd_out), 32'h9876);
        chk("t4_err", 32'(seg_err), 32'd0);
        digit(2, 3, 20);
        digit(1, 3, 20);
        digit(0, 3, 20);
        drive(4'b0011, pat[0], 300);
        digit(3, 2, 20);
        blank(20);
        chk("t4_multi_low_ignored", 32'(bcd_out), 32'h2333);

        scan4(2, 4, 6, 8);
        while (cycle < last_stb_cycle + TMO - 20) @(negedge clk);
        chk("t5_valid_before", 32'(frame_valid), 32'd1);
        chk("t5_timeout_before", 32'(timeout), 32'd0);
        while (cycle < last_stb_cycle + TMO + 20) @(negedge clk);
        chk("t5_valid_after", 32'(frame_valid), 32'd0);
        chk("t5_timeout_after", 32'(timeout), 32'd1);
        chk("t5_bcd_kept", 32'(bcd_out), 32'h2468);
        scan4(3, 1, 4, 1);
        chk("t5_timeout_cleared", 32'(timeout), 32'd0);
        chk("t5_valid_restored", 32'(frame_valid), 32'd1);

        digit(3, 9, 20);
        digit(2, 9, 20);
        digit(1, 9, 20);
        anode_n = 4'hF;
        seg_n   = 7'h7F;
        reset   = 1'b1;
        model_reset();
        #1;
        chk("t6_reset_bcd", 32'(bcd_out), 32'h0);
        chk("t6_reset_valid", 32'(frame_valid), 32'h0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        n0 = stb_count;
        digit(0, 8, 20);
        blank(20);
        chk("t6_no_partial_frame", 32'(stb_count - n0), 32'd0);
        scan4(5, 6, 7, 8);
        chk("t6_one_stb", 32'(stb_count - n0), 32'd1);
        chk("t6_bcd", 32'(bcd_out), 32'h5678);

        for (int k = 0; k < 400; k++) begin
            r   = int'($urandom_range(0, 99));
            len = int'($urandom_range(SETTLE + 3, 25));
            if (r < 55) begin
                digit(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), len);
            end else if (r < 63) begin
                drive(~(4'b0001 << $urandom_range(0, 3)), 7'($urandom), len);
            end else if (r < 78) begin
                blank(len);
            end else if (r < 92) begin
                drive(4'($urandom), 7'($urandom), int'($urandom_range(1, SETTLE - 1)));
            end else begin
                case ($urandom_range(0, 3))
                    0: an = 4'b0011;
                    1: an = 4'b0101;
                    2: an = 4'b0000;
                    default: an = 4'b1001;
                endcase
                drive(an, pat[$urandom_range(0, 9)], len);
            end
        end
        blank(50);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_count", 32'(stb_count), 32'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
